// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the sha256 core, the sha256_padder feeder and the
//   bitcoin top.
//   Contents:
//     padder_state_t           - padder FSM states (FILL, PAD, EMIT, LENBLK)
//     BLOCK_W, WORD_W, LEN_W   - block, word and message-length widths
//     pad_word(data, nbytes)   - keeps the first nbytes bytes of a word, then
//                                inserts the 0x80 marker byte and clears the
//                                remaining lower bytes
package sha256_pkg;

  localparam int BLOCK_W = 512;
  localparam int WORD_W  = 32;
  localparam int LEN_W   = 64;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    EMIT,
    LENBLK
  } padder_state_t;

  // Bytes are left-justified, so the marker goes directly below the last
  // valid byte. Four valid bytes leave no room; the caller then pads the
  // following word, using nbytes 0.
  function automatic logic [31:0] pad_word(input logic [31:0] data,
                                           input logic [2:0]  nbytes);
    logic [31:0] w;
    case (nbytes)
      3'd0:    w = 32'h8000_0000;
      3'd1:    w = {data[31:24], 24'h80_0000};
      3'd2:    w = {data[31:16], 16'h8000};
      3'd3:    w = {data[31:8],  8'h80};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// sha256_padder
//   Accepts a message as 32-bit big-endian words and emits FIPS 180-4 padded
//   512-bit blocks for the sha256 core.
//   Ports:
//     clk, reset                   - rising-edge clock, async active-high reset
//     in_valid/in_ready            - input word handshake
//     in_data, in_last, in_nbytes  - message word (first byte in [31:24]),
//                                    final-word flag, valid byte count 0..4
//     blk_valid/blk_ready          - output block handshake
//     blk_data                     - block, word 0 in [511:480]
//     blk_first, blk_last          - first/final block of the message
module sha256_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [2:0]         in_nbytes,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last
);

  padder_state_t state, state_next;

  logic [3:0]       idx;
  logic [4:0]       pad_pos;
  logic [2:0]       pad_off;
  logic [LEN_W-1:0] bitlen;
  logic             first;
  logic             pend_len;
  logic             pad_next;

  // Input and output never overlap: words are only taken while filling.
  assign in_ready = (state == FILL) & ~reset;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Next-state logic. In FILL in_ready is high, so in_valid alone is the
  // handshake; in EMIT blk_valid is high, so blk_ready alone is.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (in_valid) begin
          if (in_last)           state_next = PAD;
          else if (idx == 4'd15) state_next = EMIT;
        end
      end
      PAD:    state_next = EMIT;
      EMIT: begin
        if (blk_ready) state_next = pend_len ? LENBLK : FILL;
      end
      LENBLK: state_next = EMIT;
      default: state_next = FILL;
    endcase
  end

  // Datapath. blk_data doubles as the word buffer while filling; it is only
  // visible to the consumer once blk_valid rises, and is frozen until the
  // handshake. The padded tail position pad_pos counts words 0..16, where 16
  // means the marker byte spills into the extra length-only block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      pad_pos   <= '0;
      pad_off   <= '0;
      bitlen    <= '0;
      first     <= 1'b1;
      pend_len  <= 1'b0;
      pad_next  <= 1'b0;
      blk_valid <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
      blk_data  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) begin
              if (idx == 4'(i)) blk_data[BLOCK_W-1-WORD_W*i -: WORD_W] <= in_data;
            end
            bitlen <= bitlen + {58'd0, in_nbytes, 3'd0};
            if (in_last) begin
              pad_pos <= {1'b0, idx} + ((in_nbytes == 3'd4) ? 5'd1 : 5'd0);
              pad_off <= (in_nbytes == 3'd4) ? 3'd0 : in_nbytes;
            end else if (idx == 4'd15) begin
              blk_valid <= 1'b1;
              blk_first <= first;
              blk_last  <= 1'b0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        // The length words are assigned after the zero fill so they win when
        // the tail leaves room for them in this block.
        PAD: begin
          for (int i = 0; i < 16; i++) begin
            if (5'(i) == pad_pos)
              blk_data[BLOCK_W-1-WORD_W*i -: WORD_W] <=
                pad_word(blk_data[BLOCK_W-1-WORD_W*i -: WORD_W], pad_off);
            else if (5'(i) > pad_pos)
              blk_data[BLOCK_W-1-WORD_W*i -: WORD_W] <= '0;
          end
          if (pad_pos <= 5'd13) begin
            blk_data[LEN_W-1:0] <= bitlen;
            blk_last            <= 1'b1;
          end else begin
            pend_len <= 1'b1;
            pad_next <= (pad_pos == 5'd16);
            blk_last <= 1'b0;
          end
          blk_valid <= 1'b1;
          blk_first <= first;
        end

        EMIT: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_first <= 1'b0;
            blk_last  <= 1'b0;
            first     <= 1'b0;
            if (!pend_len) begin
              idx <= '0;
              if (blk_last) begin
                bitlen <= '0;
                first  <= 1'b1;
              end
            end
          end
        end

        LENBLK: begin
          blk_data  <= {(pad_next ? 32'h8000_0000 : 32'h0), 416'd0, bitlen};
          blk_valid <= 1'b1;
          blk_first <= 1'b0;
          blk_last  <= 1'b1;
          pend_len  <= 1'b0;
          pad_next  <= 1'b0;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder
//   Self-checking bench for sha256_padder. A byte-level padding model builds
//   the expected blocks for each message and pushes them to a scoreboard; a
//   consumer process pops and compares each block the DUT presents.
module tb_sha256_padder;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  blk_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   holdCount  = 0;

  sha256_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the last word of a message may carry fewer than four bytes.
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready && !in_last)
      assert (in_nbytes == 3'd4) else $error("[TB] short word without in_last");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [511:0] obs,
                             input logic [511:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer: holds blk_ready low for holdCount cycles on the first block it
  // sees (checking that the block and in_ready stay put), then takes it.
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!blk_valid || reset) begin
        blk_ready = 1'b0;
      end else if (sb.size() == 0) begin
        checkOutput("unexpected_blk", 1, 0);
        blk_ready = 1'b1;
      end else if (holdCount > 0) begin
        blk_ready = 1'b0;
        checkOutput("hold_data", blk_data, sb[0].data);
        checkOutput("hold_in_ready", in_ready, 0);
        holdCount--;
      end else begin
        blk_t e;
        e = sb.pop_front();
        checkOutput("blk_data", blk_data, e.data);
        checkOutput("blk_first", blk_first, e.first);
        checkOutput("blk_last", blk_last, e.last);
        blk_ready = 1'b1;
      end
    end
  end

  // Presents one word from a negedge and returns at the negedge after it is
  // accepted. The wait for in_ready is bounded.
  task automatic driveWord(input logic [31:0] w, input logic last,
                           input logic [2:0] nb);
    int guard = 0;
    in_valid  = 1'b1;
    in_data   = w;
    in_last   = last;
    in_nbytes = nb;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) checkOutput("in_ready_timeout", 0, 1);
    else @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Builds a message, models its padding into the scoreboard, then drives it.
  // zeroTail ends a word-aligned message with an extra nbytes-0 last word.
  task automatic applyStimulus(input string name, input int len,
                               input bit useAbc, input bit zeroTail);
    logic [7:0]  msg[$];
    logic [7:0]  pad[$];
    logic [63:0] bl;
    logic [31:0] w;
    blk_t        e;
    int          nblk, nwords, nb;
    bit          last;
    for (int i = 0; i < len; i++)
      msg.push_back(useAbc ? 8'(8'h61 + i) : 8'($urandom_range(0, 255)));
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bl = 64'(len) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bl[8*k +: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = pad[64*b+j];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      sb.push_back(e);
    end
    nwords = len / 4 + ((len % 4 != 0 || zeroTail || len == 0) ? 1 : 0);
    for (int k = 0; k < nwords; k++) begin
      nb = (len - 4*k >= 4) ? 4 : len - 4*k;
      w  = '0;
      for (int j = 0; j < nb; j++) w[31-8*j -: 8] = msg[4*k+j];
      last = (k == nwords - 1);
      driveWord(w, last, 3'(nb));
      if (last) begin
        checkOutput({name, "_pad_gap"}, blk_valid, 0);
        @(negedge clk);
        checkOutput({name, "_valid_lat"}, blk_valid, 1);
      end else if (k % 16 == 15) begin
        checkOutput({name, "_full_lat"}, blk_valid, 1);
      end
    end
  endtask

  // Waits (bounded) until every expected block has been consumed.
  task automatic waitDrain(input string name);
    int g = 0;
    while ((sb.size() != 0 || blk_valid) && g < 500) begin
      @(negedge clk);
      g++;
    end
    checkOutput({name, "_drained"}, 512'(sb.size()), 0);
  endtask

  // Main sequence.
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbytes = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_blk_valid", blk_valid, 0);
    checkOutput("rst_blk_data", blk_data, 0);
    checkOutput("rst_blk_first", blk_first, 0);
    checkOutput("rst_blk_last", blk_last, 0);
    reset = 1'b0;
    #1 checkOutput("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    applyStimulus("abc", 3, 1'b1, 1'b0);    waitDrain("abc");
    applyStimulus("empty", 0, 1'b0, 1'b0);  waitDrain("empty");
    applyStimulus("b55", 55, 1'b0, 1'b0);   waitDrain("b55");
    applyStimulus("b56", 56, 1'b0, 1'b0);   waitDrain("b56");
    holdCount = 10;
    applyStimulus("b64", 64, 1'b0, 1'b0);   waitDrain("b64");
    applyStimulus("b60", 60, 1'b0, 1'b0);   waitDrain("b60");
    applyStimulus("b8z", 8, 1'b0, 1'b1);    waitDrain("b8z");
    applyStimulus("b100", 100, 1'b0, 1'b0); waitDrain("b100");

    // Reset while the first block of a two-block message is being presented.
    holdCount = 1000;
    applyStimulus("rst56", 56, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midemit_blk_valid", blk_valid, 0);
    checkOutput("midemit_in_ready", in_ready, 0);
    sb.delete();
    holdCount = 0;
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("rerelease_in_ready", in_ready, 1);
    @(negedge clk);
    applyStimulus("abc2", 3, 1'b1, 1'b0);   waitDrain("abc2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
